// File: rtl/eth_pkg.sv
// Ethernet MAC Control constants and the rx PAUSE parser state type.
package eth_pkg;

  localparam logic [47:0] PAUSE_MCAST_DA        = 48'h0180C2000001;
  localparam logic [15:0] ETHERTYPE_MAC_CTRL    = 16'h8808;
  localparam logic [15:0] OPCODE_PAUSE          = 16'h0001;
  localparam int unsigned PAUSE_QUANTA_CYC_GMII = 64;
  localparam int unsigned PAUSE_QUANTA_CYC_MII  = 128;

  typedef enum logic [1:0] {IDLE, PARSE, DROP} rx_pause_state_e;

  // Byte idx of a MAC address in wire order (idx 0 is the most significant byte).
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = mac[47:40];
      3'd1:    b = mac[39:32];
      3'd2:    b = mac[31:24];
      3'd3:    b = mac[23:16];
      3'd4:    b = mac[15:8];
      3'd5:    b = mac[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/pause_quanta_timer.sv
// Pause quanta down-counter: one quantum is 512 bit times, paced by a cycle subcounter.
module pause_quanta_timer
  import eth_pkg::*;
#(
  parameter int unsigned QUANTA_WIDTH = 16
) (
  input  logic                    rgmii_mac_rx_clk,
  input  logic                    reset_n,
  input  logic                    mii_sel,
  input  logic                    load,
  input  logic [QUANTA_WIDTH-1:0] load_quanta,
  output logic [QUANTA_WIDTH-1:0] quanta,
  output logic                    active
);

  logic [QUANTA_WIDTH-1:0] quanta_q, quanta_d;
  logic [6:0]              sub_q, sub_d;
  logic [6:0]              terminal;

  // Nibble mode moves 4 bits per clock, so a quantum takes twice the cycles.
  assign terminal = mii_sel ? 7'(PAUSE_QUANTA_CYC_MII - 1) : 7'(PAUSE_QUANTA_CYC_GMII - 1);

  // Next-state: a load overrides any decrement due in the same cycle.
  always_comb begin
    quanta_d = quanta_q;
    sub_d    = sub_q;
    if (load) begin
      quanta_d = load_quanta;
      sub_d    = 7'd0;
    end else if (quanta_q != '0) begin
      // >= rather than == so a mode switch mid-quantum cannot overshoot.
      if (sub_q >= terminal) begin
        sub_d    = 7'd0;
        quanta_d = quanta_q - QUANTA_WIDTH'(1);
      end else begin
        sub_d = sub_q + 7'd1;
      end
    end
  end

  // Timer state registers.
  always_ff @(posedge rgmii_mac_rx_clk) begin
    if (!reset_n) begin
      quanta_q <= '0;
      sub_q    <= 7'd0;
    end else begin
      quanta_q <= quanta_d;
      sub_q    <= sub_d;
    end
  end

  assign quanta = quanta_q;
  assign active = (quanta_q != '0);

endmodule

// File: rtl/rx_pause_ctrl.sv
// Passive rx-stream monitor: detects 802.3x PAUSE frames and drives the pause timer.
module rx_pause_ctrl
  import eth_pkg::*;
#(
  parameter logic [47:0] STATION_MAC  = 48'h0000_0000_0000,
  parameter int unsigned CNT_WIDTH    = 16,
  parameter int unsigned QUANTA_WIDTH = 16
) (
  input  logic                    rgmii_mac_rx_clk,
  input  logic                    reset_n,
  input  logic [7:0]              s_axis_tdata,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tuser,
  input  logic                    s_axis_trdy,
  input  logic                    mii_sel,
  output logic                    rx_pause,
  output logic [QUANTA_WIDTH-1:0] pause_quanta,
  output logic                    pause_frame_pulse,
  output logic [CNT_WIDTH-1:0]    pause_frame_cnt,
  output logic [CNT_WIDTH-1:0]    ctrl_err_cnt
);

  localparam logic UNI_EN = (STATION_MAC != 48'h0);

  rx_pause_state_e         state_q, state_d;
  logic [4:0]              idx_q, idx_d;
  logic                    mcast_ok_q, mcast_ok_d, uni_ok_q, uni_ok_d;
  logic [QUANTA_WIDTH-1:0] pt_q, pt_d;
  logic [CNT_WIDTH-1:0]    pcnt_q, ecnt_q;
  logic                    pulse_q;
  logic                    beat, byte_ok, mcast_hit, uni_hit, accept, ctrl_err;

  assign beat = s_axis_tvalid && s_axis_trdy;

  // Compare the current byte with what a PAUSE frame carries at this index.
  always_comb begin
    mcast_hit = 1'b0;
    uni_hit   = 1'b0;
    byte_ok   = 1'b1;
    case (idx_q)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5: begin
        // Both DA candidates are tracked; only when both have failed is it a mismatch.
        mcast_hit = ((idx_q == 5'd0) || mcast_ok_q) &&
                    (s_axis_tdata == mac_byte(PAUSE_MCAST_DA, idx_q[2:0]));
        uni_hit   = (((idx_q == 5'd0) && UNI_EN) || uni_ok_q) &&
                    (s_axis_tdata == mac_byte(STATION_MAC, idx_q[2:0]));
        byte_ok   = mcast_hit || uni_hit;
      end
      5'd12:   byte_ok = (s_axis_tdata == ETHERTYPE_MAC_CTRL[15:8]);
      5'd13:   byte_ok = (s_axis_tdata == ETHERTYPE_MAC_CTRL[7:0]);
      5'd14:   byte_ok = (s_axis_tdata == OPCODE_PAUSE[15:8]);
      5'd15:   byte_ok = (s_axis_tdata == OPCODE_PAUSE[7:0]);
      default: byte_ok = 1'b1;
    endcase
  end

  // Parser FSM next-state, frame verdict, and shadow/DA-flag updates.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    ctrl_err   = 1'b0;
    idx_d      = idx_q;
    mcast_ok_d = mcast_ok_q;
    uni_ok_d   = uni_ok_q;
    pt_d       = pt_q;
    if (beat) begin
      if (s_axis_tlast) begin
        idx_d = 5'd0;
      end else if (idx_q < 5'd18) begin
        idx_d = idx_q + 5'd1;
      end
    end
    case (state_q)
      IDLE, PARSE: begin
        if (beat) begin
          if (idx_q < 5'd6) begin
            mcast_ok_d = mcast_hit;
            uni_ok_d   = uni_hit;
          end
          if (idx_q == 5'd16) pt_d[15:8] = s_axis_tdata;
          if (idx_q == 5'd17) pt_d[7:0]  = s_axis_tdata;
          if (s_axis_tlast) begin
            state_d = IDLE;
            // A frame that already mismatched is not a control frame and is not an error.
            if (byte_ok) begin
              if (!s_axis_tuser && (idx_q >= 5'd17)) accept   = 1'b1;
              else                                    ctrl_err = 1'b1;
            end
          end else if (!byte_ok) begin
            state_d = DROP;
          end else begin
            state_d = PARSE;
          end
        end
      end
      DROP: begin
        if (beat && s_axis_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Parser state, shadow pause_time, statistics and accept pulse.
  always_ff @(posedge rgmii_mac_rx_clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      idx_q      <= 5'd0;
      mcast_ok_q <= 1'b0;
      uni_ok_q   <= 1'b0;
      pt_q       <= '0;
      pcnt_q     <= '0;
      ecnt_q     <= '0;
      pulse_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      mcast_ok_q <= mcast_ok_d;
      uni_ok_q   <= uni_ok_d;
      pt_q       <= pt_d;
      pulse_q    <= accept;
      if (accept && !(&pcnt_q))  pcnt_q <= pcnt_q + CNT_WIDTH'(1);
      if (ctrl_err && !(&ecnt_q)) ecnt_q <= ecnt_q + CNT_WIDTH'(1);
    end
  end

  // Load with pt_d so a pause_time LSB arriving on the tlast beat is included.
  pause_quanta_timer #(
    .QUANTA_WIDTH(QUANTA_WIDTH)
  ) u_timer (
    .rgmii_mac_rx_clk(rgmii_mac_rx_clk),
    .reset_n         (reset_n),
    .mii_sel         (mii_sel),
    .load            (accept),
    .load_quanta     (pt_d),
    .quanta          (pause_quanta),
    .active          (rx_pause)
  );

  assign pause_frame_pulse = pulse_q;
  assign pause_frame_cnt   = pcnt_q;
  assign ctrl_err_cnt      = ecnt_q;

endmodule

// File: tb/tb_rx_pause_ctrl.sv
// Self-checking bench for rx_pause_ctrl: vector table, corner sequences, random frames.
module tb_rx_pause_ctrl;

  localparam logic [47:0] STATION = 48'h020000000001;
  localparam logic [47:0] MCAST   = 48'h0180C2000001;
  localparam int          CW      = 4;
  localparam int          CMAX    = 15;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  tdata = 8'h00;
  logic        tvalid = 1'b0, tlast = 1'b0, tuser = 1'b0, trdy = 1'b0, mii_sel = 1'b0;
  logic        rx_pause, pause_frame_pulse;
  logic [15:0] pause_quanta;
  logic [CW-1:0] pause_frame_cnt, ctrl_err_cnt;

  always #4 clk = ~clk;

  rx_pause_ctrl #(
    .STATION_MAC (STATION),
    .CNT_WIDTH   (CW),
    .QUANTA_WIDTH(16)
  ) dut (
    .rgmii_mac_rx_clk (clk),
    .reset_n          (reset_n),
    .s_axis_tdata     (tdata),
    .s_axis_tvalid    (tvalid),
    .s_axis_tlast     (tlast),
    .s_axis_tuser     (tuser),
    .s_axis_trdy      (trdy),
    .mii_sel          (mii_sel),
    .rx_pause         (rx_pause),
    .pause_quanta     (pause_quanta),
    .pause_frame_pulse(pause_frame_pulse),
    .pause_frame_cnt  (pause_frame_cnt),
    .ctrl_err_cnt     (ctrl_err_cnt)
  );

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pause expressed as remaining bit times, frame verdicts from the driver.
  int          rem_bits = 0;
  int          m_pcnt = 0, m_ecnt = 0;
  bit          m_pulse = 1'b0;
  int          ev_kind = 0;  // 0 none, 1 accept, 2 control error
  logic [15:0] ev_pt = 16'h0;
  logic        m_last;
  assign m_last = tvalid && trdy && tlast;

  always @(posedge clk) begin
    if (!reset_n) begin
      rem_bits <= 0;
      m_pcnt   <= 0;
      m_ecnt   <= 0;
      m_pulse  <= 1'b0;
    end else begin
      m_pulse <= m_last && (ev_kind == 1);
      if (m_last && ev_kind == 1) begin
        rem_bits <= int'(ev_pt) * 512;
        if (m_pcnt < CMAX) m_pcnt <= m_pcnt + 1;
      end else if (rem_bits > 0) begin
        rem_bits <= rem_bits - (mii_sel ? 4 : 8);
      end
      if (m_last && ev_kind == 2 && m_ecnt < CMAX) m_ecnt <= m_ecnt + 1;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("rx_pause", rx_pause, rem_bits > 0);
      chk("pause_quanta", pause_quanta, (rem_bits + 511) / 512);
      chk("pause_pulse", pause_frame_pulse, m_pulse);
      chk("pause_frame_cnt", pause_frame_cnt, m_pcnt);
      chk("ctrl_err_cnt", ctrl_err_cnt, m_ecnt);
    end
  end

  logic [7:0] frm[$];

  task automatic build(input logic [47:0] da, input logic [15:0] et, input logic [15:0] op,
                       input logic [15:0] pt, input int len);
    logic [47:0] d;
    d = da;
    frm.delete();
    for (int i = 0; i < len; i++) begin
      if (i < 6)        frm.push_back(d[47-8*i -: 8]);
      else if (i < 12)  frm.push_back(8'(8'h10 + i));
      else if (i == 12) frm.push_back(et[15:8]);
      else if (i == 13) frm.push_back(et[7:0]);
      else if (i == 14) frm.push_back(op[15:8]);
      else if (i == 15) frm.push_back(op[7:0]);
      else if (i == 16) frm.push_back(pt[15:8]);
      else if (i == 17) frm.push_back(pt[7:0]);
      else              frm.push_back(8'($urandom));
    end
  endtask

  // Frame-level verdict for frm[lo..hi] as one received frame.
  function automatic int eval_frame(input int lo, input int hi, input bit tu,
                                    output logic [15:0] pt);
    logic [47:0] mc, st;
    bit mc_ok, st_ok, ok;
    int n;
    mc = MCAST;
    st = STATION;
    mc_ok = 1'b1;
    st_ok = (STATION != 48'h0);
    ok = 1'b1;
    n = hi - lo + 1;
    pt = 16'h0;
    for (int j = 0; j < n && j < 18; j++) begin
      if (j < 6) begin
        mc_ok = mc_ok && (frm[lo+j] == mc[47-8*j -: 8]);
        st_ok = st_ok && (frm[lo+j] == st[47-8*j -: 8]);
        if (!mc_ok && !st_ok) ok = 1'b0;
      end
      if (j == 12 && frm[lo+j] != 8'h88) ok = 1'b0;
      if (j == 13 && frm[lo+j] != 8'h08) ok = 1'b0;
      if (j == 14 && frm[lo+j] != 8'h00) ok = 1'b0;
      if (j == 15 && frm[lo+j] != 8'h01) ok = 1'b0;
      if (j == 16) pt[15:8] = frm[lo+j];
      if (j == 17) pt[7:0]  = frm[lo+j];
    end
    if (!ok) return 0;
    if (n < 18 || tu) return 2;
    return 1;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      tvalid  = 1'b0;
      tdata   = 8'($urandom);
      tlast   = 1'($urandom);
      tuser   = 1'($urandom);
      trdy    = 1'($urandom);
      ev_kind = 0;
      @(posedge clk);
      #1;
    end
  endtask

  // gap: 0 back-to-back, 1 one idle cycle between bytes, 2 random gaps and trdy stalls.
  task automatic send_bytes(input int lo, input int hi, input bit is_end, input bit tu,
                            input int gap);
    int k;
    bit done;
    logic [15:0] pt;
    k = is_end ? eval_frame(lo, hi, tu, pt) : 0;
    for (int i = lo; i <= hi; i++) begin
      if (gap == 1 && i != lo) idle(1);
      else if (gap == 2)       idle($urandom_range(0, 2));
      done = 1'b0;
      while (!done) begin
        tvalid  = 1'b1;
        tdata   = frm[i];
        tlast   = is_end && (i == hi);
        tuser   = tlast ? tu : 1'($urandom);
        trdy    = (gap == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
        ev_kind = tlast ? k : 0;
        ev_pt   = pt;
        done    = trdy;
        @(posedge clk);
        #1;
      end
    end
    tvalid  = 1'b0;
    tlast   = 1'b0;
    tuser   = 1'b0;
    ev_kind = 0;
  endtask

  task automatic run_frame(input logic [47:0] da, input logic [15:0] et, input logic [15:0] op,
                           input logic [15:0] pt, input int len, input bit tu, input int gap);
    build(da, et, op, pt, len);
    send_bytes(0, len - 1, 1'b1, tu, gap);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle(3);
    mon_en  = 1'b1;
    reset_n = 1'b1;
  endtask

  // Count cycles rx_pause stays high, bounded.
  task automatic measure_high(output int n);
    n = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (rx_pause) n++;
      else break;
    end
  endtask

  typedef struct {
    logic [47:0] da;
    logic [15:0] et;
    logic [15:0] op;
    logic [15:0] pt;
    int          len;
    bit          tu;
    int          acc;
    int          err;
  } vec_t;

  vec_t tbl[12];
  int   n_hi, exp_p, exp_e;

  initial begin
    tbl[0]  = '{MCAST,           16'h8808, 16'h0001, 16'h0002, 60, 1'b0, 1, 0};
    tbl[1]  = '{MCAST,           16'h0800, 16'h0001, 16'h0002, 60, 1'b0, 0, 0};
    tbl[2]  = '{MCAST,           16'h8808, 16'h0101, 16'h0002, 60, 1'b0, 0, 0};
    tbl[3]  = '{48'h0180C2000002, 16'h8808, 16'h0001, 16'h0002, 60, 1'b0, 0, 0};
    tbl[4]  = '{MCAST,           16'h8808, 16'h0001, 16'h0004, 60, 1'b1, 0, 1};
    tbl[5]  = '{MCAST,           16'h8808, 16'h0001, 16'h0004, 16, 1'b0, 0, 1};
    tbl[6]  = '{STATION,         16'h8808, 16'h0001, 16'h0001, 64, 1'b0, 1, 0};
    tbl[7]  = '{48'h020000000002, 16'h8808, 16'h0001, 16'h0001, 60, 1'b0, 0, 0};
    tbl[8]  = '{MCAST,           16'h8808, 16'h0001, 16'h0005, 18, 1'b0, 1, 0};
    tbl[9]  = '{MCAST,           16'h8808, 16'h0001, 16'h0005, 17, 1'b0, 0, 1};
    tbl[10] = '{MCAST,           16'h0800, 16'h0001, 16'h0005, 14, 1'b0, 0, 0};
    tbl[11] = '{MCAST,           16'h8808, 16'h0001, 16'h0000, 60, 1'b0, 1, 0};

    do_reset();
    chk("reset_rx_pause", rx_pause, 0);
    chk("reset_quanta", pause_quanta, 0);
    chk("reset_cnt", pause_frame_cnt, 0);

    // Vector table: cumulative counter expectations after each frame.
    exp_p = 0;
    exp_e = 0;
    for (int i = 0; i < 12; i++) begin
      run_frame(tbl[i].da, tbl[i].et, tbl[i].op, tbl[i].pt, tbl[i].len, tbl[i].tu, i % 3);
      idle(3);
      exp_p += tbl[i].acc;
      exp_e += tbl[i].err;
      chk($sformatf("tbl%0d_pcnt", i), pause_frame_cnt, exp_p);
      chk($sformatf("tbl%0d_ecnt", i), ctrl_err_cnt, exp_e);
    end

    // 1 Gbps, two quanta: 128 cycles of pause.
    do_reset();
    mii_sel = 1'b0;
    run_frame(MCAST, 16'h8808, 16'h0001, 16'h0002, 60, 1'b0, 0);
    chk("gmii_pulse", pause_frame_pulse, 1);
    measure_high(n_hi);
    chk("gmii_hold", n_hi, 128);
    chk("gmii_pcnt", pause_frame_cnt, 1);

    // Nibble mode, three quanta, tvalid toggling: 384 cycles.
    mii_sel = 1'b1;
    run_frame(MCAST, 16'h8808, 16'h0001, 16'h0003, 60, 1'b0, 1);
    measure_high(n_hi);
    chk("mii_hold", n_hi, 384);
    mii_sel = 1'b0;

    // XON cuts a long pause short.
    run_frame(MCAST, 16'h8808, 16'h0001, 16'hFFFF, 60, 1'b0, 0);
    idle(1000);
    chk("xoff_active", rx_pause, 1);
    run_frame(MCAST, 16'h8808, 16'h0001, 16'h0000, 60, 1'b0, 0);
    @(negedge clk);
    chk("xon_rx_pause", rx_pause, 0);
    chk("xon_quanta", pause_quanta, 0);

    // Reset mid-frame abandons it; tail bytes must not be taken as a frame.
    do_reset();
    build(MCAST, 16'h8808, 16'h0001, 16'h0007, 60);
    send_bytes(0, 9, 1'b0, 1'b0, 0);
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    send_bytes(10, 59, 1'b1, 1'b0, 0);
    run_frame(MCAST, 16'h8808, 16'h0001, 16'h0001, 60, 1'b0, 0);
    measure_high(n_hi);
    chk("abort_hold", n_hi, 64);
    chk("abort_pcnt", pause_frame_cnt, 1);
    run_frame(STATION, 16'h8808, 16'h0001, 16'h0001, 60, 1'b0, 2);
    idle(2);
    chk("unicast_pcnt", pause_frame_cnt, 2);

    // Random frames against the model; mode only switches while idle.
    do_reset();
    for (int f = 0; f < 150; f++) begin
      logic [47:0] da;
      logic [15:0] et, op, pt;
      int sel, len;
      if (rem_bits == 0 && $urandom_range(0, 3) == 0) mii_sel = 1'($urandom);
      sel = $urandom_range(0, 9);
      da  = (sel < 5) ? MCAST : (sel < 7) ? STATION :
            (sel == 7) ? 48'h0180C2000002 : {16'($urandom), 32'($urandom)};
      et  = ($urandom_range(0, 7) != 0) ? 16'h8808 : 16'h0800;
      op  = ($urandom_range(0, 7) != 0) ? 16'h0001 : 16'h0101;
      pt  = ($urandom_range(0, 19) != 0) ? 16'($urandom_range(0, 4)) : 16'($urandom);
      len = ($urandom_range(0, 5) == 0) ? $urandom_range(15, 19) : $urandom_range(8, 70);
      run_frame(da, et, op, pt, len, ($urandom_range(0, 7) == 0), $urandom_range(0, 2));
      idle($urandom_range(0, 5));
      if ($urandom_range(0, 5) == 0 && rem_bits <= 5 * 1024) begin
        for (int c = 0; c < 3000 && rem_bits != 0; c++) idle(1);
        chk("rand_expire", rx_pause, 0);
      end
    end
    run_frame(MCAST, 16'h8808, 16'h0001, 16'h0000, 60, 1'b0, 0);
    idle(2);
    chk("rand_pcnt_sat", pause_frame_cnt, m_pcnt);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
